// File: rtl/i2s_capture_pkg.sv
// ============================================================================
// Module   : i2s_capture_pkg
// Brief    : Shared state encoding and constants for the I2S capture block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2s_capture_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int OUT_W       = 16;
  localparam int ERR_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_capture_sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchronizer with registered rise and fall pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge_det
  import i2s_capture_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

`default_nettype wire

// File: rtl/i2s_capture.sv
// ============================================================================
// Module   : i2s_capture
// Brief    : Captures one I2S slot into a 16-bit signed sample with a strobe.
//            Define I2S_CAPTURE_ERR_CNT_EN to add the o_err_cnt abort counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_capture
  import i2s_capture_pkg::*;
#(
  parameter int LEFT_CH   = 1,
  parameter int WORD_BITS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_bclk,
  input  logic                    i_lrck,
  input  logic                    i_adcdat,
  input  logic                    i_enable,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_valid
`ifdef I2S_CAPTURE_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]        o_err_cnt
`endif
);

  localparam int                CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic                          w_bclk_rise;
  logic                          w_bclk_fall;
  logic                          w_lrck_rise;
  logic                          w_lrck_fall;
  logic                          w_bit_stb;
  logic                          w_lrck_ev;
  logic                          w_enter;
  logic                          w_abort;

  logic [SYNC_STAGES-1:0]        adc_sync_q;
  logic                          adc_al_q;
  logic                          armed_q;
  state_e                        state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [WORD_BITS-1:0]          shift_q;
  logic [WORD_BITS-1:0]          shift_d;
  logic signed [OUT_W-1:0]       data_q;
  logic                          valid_q;

  sync_edge_det u_bclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_bclk),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  sync_edge_det u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_lrck),
    .o_rise  (w_lrck_rise),
    .o_fall  (w_lrck_fall)
  );

  // Extra stage lines the data bit up with the registered bclk rise pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      adc_sync_q <= '0;
      adc_al_q   <= 1'b0;
    end else begin
      adc_sync_q <= {adc_sync_q[SYNC_STAGES-2:0], i_adcdat};
      adc_al_q   <= adc_sync_q[SYNC_STAGES-1];
    end
  end

  // The first lrck edge after reset is an artefact of the zeroed synchronizer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      armed_q <= 1'b0;
    end else if (w_lrck_rise | w_lrck_fall) begin
      armed_q <= 1'b1;
    end
  end

  assign w_bit_stb = w_bclk_rise & ~w_bclk_fall;
  assign w_lrck_ev = (w_lrck_rise | w_lrck_fall) & armed_q;
  assign w_enter   = ((LEFT_CH != 0) ? w_lrck_fall : w_lrck_rise) & armed_q;
  assign w_abort   = i_enable & w_lrck_ev &
                     ((state_q == ST_SKIP) || (state_q == ST_SHIFT));
  assign shift_d   = {shift_q[WORD_BITS-2:0], adc_al_q};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!i_enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (state_q == ST_DONE) begin
        data_q  <= shift_q[WORD_BITS-1 -: OUT_W];
        valid_q <= 1'b1;
        state_q <= ST_WAIT;
      end else if (w_lrck_ev) begin
        cnt_q <= '0;
        if (w_enter) begin
          state_q <= ST_SKIP;
        end else if (w_abort) begin
          state_q <= ST_IDLE;
        end
      end else if (w_bit_stb) begin
        case (state_q)
          ST_SKIP: state_q <= ST_SHIFT;
          ST_SHIFT: begin
            shift_q <= shift_d;
            if (cnt_q == LAST_BIT) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

`ifdef I2S_CAPTURE_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else if (w_abort) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_capture.sv
// ============================================================================
// Module   : tb_i2s_capture
// Brief    : Directed plus random I2S frames into three capture configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_capture;

  localparam int N = 3;
  localparam int CH_LEFT [N] = '{1, 0, 1};
  localparam int WBITS   [N] = '{16, 16, 24};

  logic clk = 1'b0;
  logic rst_n, bclk, lrck, adcdat, enable;
  logic signed [15:0] data_w  [N];
  logic               valid_w [N];
`ifdef I2S_CAPTURE_ERR_CNT_EN
  logic [7:0]         err_w   [N];
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_capture #(.LEFT_CH(1), .WORD_BITS(16)) u_dut_l16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk(bclk), .i_lrck(lrck),
    .i_adcdat(adcdat), .i_enable(enable),
    .o_data(data_w[0]), .o_valid(valid_w[0])
`ifdef I2S_CAPTURE_ERR_CNT_EN
    , .o_err_cnt(err_w[0])
`endif
  );

  i2s_capture #(.LEFT_CH(0), .WORD_BITS(16)) u_dut_r16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk(bclk), .i_lrck(lrck),
    .i_adcdat(adcdat), .i_enable(enable),
    .o_data(data_w[1]), .o_valid(valid_w[1])
`ifdef I2S_CAPTURE_ERR_CNT_EN
    , .o_err_cnt(err_w[1])
`endif
  );

  i2s_capture #(.LEFT_CH(1), .WORD_BITS(24)) u_dut_l24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk(bclk), .i_lrck(lrck),
    .i_adcdat(adcdat), .i_enable(enable),
    .o_data(data_w[2]), .o_valid(valid_w[2])
`ifdef I2S_CAPTURE_ERR_CNT_EN
    , .o_err_cnt(err_w[2])
`endif
  );

  // Output monitor and a one-register downstream gate stage per instance.
  logic        prev_v [N];
  logic        gate_v [N];
  int          pulses [N];
  int          gate_pulses [N];
  int          wide [N];
  int          rise_cyc [N];
  logic [15:0] got_q [N][$];

  always @(posedge clk) begin
    for (int d = 0; d < N; d++) gate_v[d] <= valid_w[d];
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (valid_w[d] === 1'b1) begin
        if (prev_v[d] === 1'b1) begin
          wide[d]++;
        end else begin
          pulses[d]++;
          rise_cyc[d] = cyc;
          got_q[d].push_back(data_w[d]);
        end
      end
      if (gate_v[d] === 1'b1) gate_pulses[d]++;
      prev_v[d] = valid_w[d];
    end
  end

  // Reference model state, advanced per slot from the protocol rules.
  logic        cur_lr;
  bit          ign_pending;
  bit          pend_abort [N];
  int          err_exp [N];
  logic [15:0] exp_q [N][$];
  int          bit_cyc [32];

  function automatic logic [15:0] word_top16(input logic [31:0] slot, input int w);
    logic [31:0] word;
    word = slot >> (32 - w);
    return 16'(word >> (w - 16));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ign_pending = 1'b1;
    for (int d = 0; d < N; d++) begin
      pend_abort[d] = 1'b0;
      err_exp[d]    = 0;
      exp_q[d].delete();
    end
  endtask

  task automatic model_release();
    if (cur_lr == 1'b1) ign_pending = 1'b0;
  endtask

  task automatic send_bit(input logic lr, input logic b, output int rise_at);
    @(negedge clk);
    bclk = 1'b0; lrck = lr; adcdat = b;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    rise_at = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] val, input int nbits,
                           input int drop_at);
    int  r;
    bit  lr_edge, counted, en_ok, sel;
    lr_edge = (lr != cur_lr);
    counted = lr_edge && !ign_pending;
    if (lr_edge) ign_pending = 1'b0;
    cur_lr = lr;
    en_ok  = (drop_at < 0);
    if (counted) begin
      for (int d = 0; d < N; d++) begin
        if (pend_abort[d] && err_exp[d] < 255) err_exp[d]++;
        pend_abort[d] = 1'b0;
      end
    end
    send_bit(lr, 1'($urandom), r);
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) enable = 1'b0;
      send_bit(lr, val[31-i], r);
      bit_cyc[i] = r;
    end
    enable = 1'b1;
    if (counted && en_ok) begin
      for (int d = 0; d < N; d++) begin
        sel = (lr == ((CH_LEFT[d] != 0) ? 1'b0 : 1'b1));
        if (sel) begin
          if (nbits >= WBITS[d]) exp_q[d].push_back(word_top16(val, WBITS[d]));
          else pend_abort[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_step(input string tag);
    repeat (16) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("%s.dut%0d.count", tag, d), got_q[d].size(), exp_q[d].size());
      while (got_q[d].size() > 0 && exp_q[d].size() > 0)
        check($sformatf("%s.dut%0d.data", tag, d), got_q[d].pop_front(), exp_q[d].pop_front());
      got_q[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic check_err(input string tag);
`ifdef I2S_CAPTURE_ERR_CNT_EN
    for (int d = 0; d < N; d++)
      check($sformatf("%s.dut%0d.err_cnt", tag, d), err_w[d], err_exp[d]);
`else
    vectors = vectors + 0;
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; bclk = 1'b0; lrck = 1'b1; adcdat = 1'b0;
    cur_lr = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset.dut%0d.data", d), $unsigned(data_w[d]), 32'h0);
      check($sformatf("reset.dut%0d.valid", d), valid_w[d], 32'h0);
    end
    rst_n = 1'b1;
    model_release();
    repeat (8) @(negedge clk);
    check_err("reset");

    // Sign-bit word on the left slot, full-scale positive on the right.
    send_slot(1'b0, 32'h8001_0000, 32, -1);
    check("latency.l16", rise_cyc[0] - bit_cyc[15], 5);
    check("latency.l24", rise_cyc[2] - bit_cyc[23], 5);
    send_slot(1'b1, 32'h7FFF_0000, 32, -1);
    check_step("s1");

    send_slot(1'b0, 32'h1234_0000, 32, -1);
    send_slot(1'b1, 32'h7FFF_0000, 32, -1);
    check_step("s2");

    send_slot(1'b0, 32'hABCD_EF00, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);
    check_step("s3");

    // Left word cut short after 9 bits, then clean words.
    send_slot(1'b0, $urandom, 9, -1);
    send_slot(1'b1, 32'h55AA_0000, 32, -1);
    send_slot(1'b0, 32'h00FF_0000, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);
    check_step("abort");
    check_err("abort");

    // Enable dropped in the middle of a left word.
    send_slot(1'b0, $urandom, 32, 5);
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, $urandom, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);
    check_step("enable");

    // Reset asserted at bit 8 of a left word.
    send_slot(1'b0, $urandom, 8, -1);
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("midreset.dut%0d.data", d), $unsigned(data_w[d]), 32'h0);
      check($sformatf("midreset.dut%0d.valid", d), valid_w[d], 32'h0);
    end
    rst_n = 1'b1;
    model_release();
    repeat (8) @(negedge clk);
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, $urandom, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);
    check_step("after_reset");
    check_err("after_reset");

    for (int f = 0; f < 100; f++) begin
      send_slot(1'b0, $urandom, 32, -1);
      send_slot(1'b1, $urandom, 32, -1);
    end
    check_step("random");

    for (int d = 0; d < N; d++) begin
      check($sformatf("width.dut%0d", d), wide[d], 0);
      check($sformatf("gate.dut%0d", d), gate_pulses[d], pulses[d]);
    end
    check_err("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
